// File: rtl/axi_burst_rd_pkg.sv
// Shared types and constants for the AXI4 burst read master.
package axi_burst_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_END   = 2'd3
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;

  function automatic int bytes_per_burst(input int data_width, input int burst_length);
    return (burst_length + 1) * (data_width / 8);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry skid buffer; upstream ready depends only on local flops, never on tx_ready.
module axis_skid_buf #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_valid;
  logic                  rx_hs;
  logic                  tx_free;

  assign rx_ready = ~skid_valid;
  assign rx_hs    = rx_valid & rx_ready;
  assign tx_free  = ~tx_valid | tx_ready;
  assign empty    = ~tx_valid & ~skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid   <= 1'b0;
      skid_valid <= 1'b0;
    end else if (tx_free) begin
      tx_valid   <= skid_valid | rx_hs;
      skid_valid <= 1'b0;
    end else if (rx_hs) begin
      skid_valid <= 1'b1;
    end
  end

  // Data registers carry no reset; the valid flags above qualify them.
  always_ff @(posedge clk) begin
    if (tx_free) begin
      if (skid_valid)
        tx_data <= skid_data;
      else if (rx_hs)
        tx_data <= rx_data;
    end else if (rx_hs) begin
      skid_data <= rx_data;
    end
  end

endmodule

// File: rtl/axi_burst_rd.sv
// AXI4 read master issuing fixed-length INCR bursts and streaming R data to AXIS.
// Optional skid buffer on the R->AXIS path: define AXI_BURST_RD_SKID_EN.
module axi_burst_rd #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 32,
  parameter int BURST_LENGTH    = 15,
  parameter int MAX_OUTSTANDING = 4,
  parameter int NB_WIDTH        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [NB_WIDTH-1:0]   nbursts,
  output logic                  done,
  output logic                  rd_err,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  import axi_burst_rd_pkg::*;

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BPB   = bytes_per_burst(DATA_WIDTH, BURST_LENGTH);
  localparam int SIZE  = $clog2(DATA_WIDTH / 8);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] ar_addr_r;
  logic [NB_WIDTH-1:0]   ar_left;
  logic [NB_WIDTH-1:0]   r_left;
  logic [OUT_W-1:0]      outstanding;
  logic                  rd_err_r;
  logic                  active;
  logic                  ar_hs;
  logic                  r_hs;
  logic                  r_last_hs;
  logic                  r_bad;
  logic                  buf_empty;

  assign active    = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign ar_hs     = m_axi_arvalid & m_axi_arready;
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign r_last_hs = r_hs & m_axi_rlast;
  // EXOKAY is a success response; only SLVERR/DECERR flag an error.
  assign r_bad     = (m_axi_rresp != AXI_RESP_OKAY) && (m_axi_rresp != AXI_RESP_EXOKAY);

  // arvalid depends only on registered state, so it cannot drop before arready.
  assign m_axi_arvalid = (state == ST_ISSUE) && (ar_left != '0) &&
                         (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign m_axi_araddr  = ar_addr_r;
  assign m_axi_arlen   = 8'(BURST_LENGTH);
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign done          = (state == ST_END);
  assign rd_err        = rd_err_r;

`ifdef AXI_BURST_RD_SKID_EN
  logic skid_ready;

  axis_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (m_axi_rdata),
    .rx_valid (m_axi_rvalid & active),
    .rx_ready (skid_ready),
    .tx_data  (m_axis_tdata),
    .tx_valid (m_axis_tvalid),
    .tx_ready (m_axis_tready),
    .empty    (buf_empty)
  );

  assign m_axi_rready = skid_ready & active;
`else
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tvalid = m_axi_rvalid & active;
  assign m_axi_rready  = m_axis_tready & active;
  assign buf_empty     = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = (nbursts == '0) ? ST_END : ST_ISSUE;
      ST_ISSUE: if (ar_hs && (ar_left == NB_WIDTH'(1))) state_nx = ST_DRAIN;
      // Completion waits for any beats still held in the skid buffer.
      ST_DRAIN: if ((r_left == '0) && buf_empty) state_nx = ST_END;
      ST_END:   if (!start) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_addr_r   <= '0;
      ar_left     <= '0;
      r_left      <= '0;
      outstanding <= '0;
      rd_err_r    <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      ar_addr_r   <= addr;
      ar_left     <= nbursts;
      r_left      <= nbursts;
      outstanding <= '0;
      rd_err_r    <= 1'b0;
    end else begin
      if (ar_hs) begin
        ar_addr_r <= ar_addr_r + ADDR_WIDTH'(BPB);
        ar_left   <= ar_left - NB_WIDTH'(1);
      end
      if (r_last_hs && (r_left != '0))
        r_left <= r_left - NB_WIDTH'(1);
      if (r_hs && r_bad)
        rd_err_r <= 1'b1;
      case ({ar_hs, r_last_hs})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   if (outstanding != '0) outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_rd.sv
// Directed bench for axi_burst_rd with an in-order AXI slave model and AXIS sink.
module tb_axi_burst_rd;

  localparam int DW  = 64;
  localparam int AW  = 32;
  localparam int NBW = 32;
`ifdef AXI_BURST_RD_SKID_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic           clk, rst, start;
  logic [AW-1:0]  addr;
  logic [NBW-1:0] nbursts;
  logic           done, rd_err;
  logic [AW-1:0]  m_axi_araddr;
  logic [7:0]     m_axi_arlen;
  logic [2:0]     m_axi_arsize;
  logic [1:0]     m_axi_arburst;
  logic           m_axi_arvalid, m_axi_arready;
  logic [DW-1:0]  m_axi_rdata;
  logic [1:0]     m_axi_rresp;
  logic           m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DW-1:0]  m_axis_tdata;
  logic           m_axis_tvalid, m_axis_tready;

  axi_burst_rd dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .nbursts(nbursts),
    .done(done), .rd_err(rd_err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [AW-1:0] sl_q[$];
  int            beat_i   = 0;
  int            gbeat    = 0;
  int            err_beat = -1;
  int            r_hold   = 0;
  bit            arready_en  = 1'b1;
  bit            tready_rand = 1'b0;

  logic [AW-1:0] ar_log[$];
  int            ar_cyc[$];
  int            r_cyc[$];
  int            rlast_cyc[$];
  logic [DW-1:0] t_log[$];
  int            t_cyc[$];
  int            viol = 0;

  bit            s_ar, s_r, s_rlast, s_t, s_rready, s_tready;
  logic [AW-1:0] s_araddr;
  logic [DW-1:0] s_tdata;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  function automatic int count_bad(input logic [AW-1:0] base, input int n);
    int b = 0;
    for (int i = 0; i < n; i++)
      if (i >= t_log.size() || t_log[i] !== mem(base + AW'(i * 8))) b++;
    return b;
  endfunction

  // Slave + sink: drive on negedge, sample handshakes just before the next posedge.
  initial begin
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axis_tready = 1'b0;
    s_ar = 0; s_r = 0; s_rlast = 0; s_t = 0; s_rready = 0; s_tready = 0;
    s_araddr = '0; s_tdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        sl_q.delete();
        beat_i = 0;
      end else begin
        if (s_ar) begin
          sl_q.push_back(s_araddr);
          ar_log.push_back(s_araddr);
          ar_cyc.push_back(cyc);
        end
        if (s_r) begin
          r_cyc.push_back(cyc);
          gbeat++;
          if (s_rlast) begin
            rlast_cyc.push_back(cyc);
            void'(sl_q.pop_front());
            beat_i = 0;
          end else begin
            beat_i++;
          end
        end
        if (s_t) begin
          t_log.push_back(s_tdata);
          t_cyc.push_back(cyc);
        end
        if (s_rready && !s_tready) viol++;
      end
      m_axi_arready = arready_en;
      m_axis_tready = tready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (!rst && sl_q.size() != 0 && cyc >= r_hold) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem(sl_q[0] + AW'(beat_i * 8));
        m_axi_rlast  = (beat_i == 15);
        m_axi_rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
      end
      #4;
      s_ar     = m_axi_arvalid && m_axi_arready;
      s_araddr = m_axi_araddr;
      s_r      = m_axi_rvalid && m_axi_rready;
      s_rlast  = m_axi_rlast;
      s_t      = m_axis_tvalid && m_axis_tready;
      s_tdata  = m_axis_tdata;
      s_rready = m_axi_rready;
      s_tready = m_axis_tready;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_logs();
    ar_log.delete(); ar_cyc.delete(); r_cyc.delete(); rlast_cyc.delete();
    t_log.delete(); t_cyc.delete();
    gbeat = 0; viol = 0;
  endtask

  task automatic start_cmd(input logic [AW-1:0] a, input int n);
    addr = a;
    nbursts = NBW'(n);
    start = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    ok = (done === 1'b1);
  endtask

  task automatic end_cmd();
    start = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; addr = '0; nbursts = '0;
    repeat (3) tick();
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (rd_err !== 1'b0) $display("FAIL reset_rd_err: got %b want 0", rd_err); else n_pass++;
    n_checks++; if (m_axi_arvalid !== 1'b0) $display("FAIL reset_arvalid: got %b want 0", m_axi_arvalid); else n_pass++;
    n_checks++; if (m_axi_rready !== 1'b0) $display("FAIL reset_rready: got %b want 0", m_axi_rready); else n_pass++;
    n_checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); else n_pass++;
    n_checks++; if (m_axi_araddr !== '0) $display("FAIL reset_araddr: got %h want 0", m_axi_araddr); else n_pass++;
    n_checks++; if (m_axi_arlen !== 8'd15) $display("FAIL arlen: got %0d want 15", m_axi_arlen); else n_pass++;
    n_checks++; if (m_axi_arsize !== 3'd3) $display("FAIL arsize: got %0d want 3", m_axi_arsize); else n_pass++;
    n_checks++; if (m_axi_arburst !== 2'b01) $display("FAIL arburst: got %b want 01", m_axi_arburst); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [AW-1:0] base = 32'h1000_0000;
    bit ok;
    int bad, bad_lat;
    clear_logs();
    start_cmd(base, 3);
    wait_done(500, ok);
    n_checks++; if (!ok) $display("FAIL basic_done: got %b want 1 within 500 cycles", done); else n_pass++;
    n_checks++; if (ar_log.size() !== 3) $display("FAIL basic_ar_count: got %0d want 3", ar_log.size()); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      logic [AW-1:0] got = (k < ar_log.size()) ? ar_log[k] : 'x;
      n_checks++;
      if (got !== base + AW'(k * 128)) $display("FAIL basic_araddr%0d: got %h want %h", k, got, base + AW'(k * 128));
      else n_pass++;
    end
    n_checks++; if (t_log.size() !== 48) $display("FAIL basic_beats: got %0d want 48", t_log.size()); else n_pass++;
    bad = count_bad(base, 48);
    n_checks++; if (bad !== 0) $display("FAIL basic_data: got %0d bad beats want 0", bad); else n_pass++;
    bad_lat = 0;
    foreach (t_cyc[i]) if (i >= r_cyc.size() || t_cyc[i] !== r_cyc[i] + LAT) bad_lat++;
    n_checks++; if (bad_lat !== 0) $display("FAIL basic_latency: got %0d late beats want 0", bad_lat); else n_pass++;
    n_checks++; if (rd_err !== 1'b0) $display("FAIL basic_rd_err: got %b want 0", rd_err); else n_pass++;
    repeat (3) tick();
    n_checks++; if (done !== 1'b1 || ar_log.size() !== 3)
      $display("FAIL basic_end_hold: got done=%b ars=%0d want done=1 ars=3", done, ar_log.size()); else n_pass++;
    start = 1'b0;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL basic_done_fall: got %b want 0", done); else n_pass++;
    tick();
  endtask

  task automatic test_outstanding();
    logic [AW-1:0] base = 32'h2000_0000;
    bit ok;
    int nb, fifth, first_last;
    clear_logs();
    r_hold = cyc + 50;
    start_cmd(base, 8);
    wait_done(2000, ok);
    n_checks++; if (!ok) $display("FAIL outst_done: got %b want 1 within 2000 cycles", done); else n_pass++;
    n_checks++; if (ar_log.size() !== 8) $display("FAIL outst_ar_count: got %0d want 8", ar_log.size()); else n_pass++;
    first_last = (rlast_cyc.size() != 0) ? rlast_cyc[0] : -100;
    nb = 0;
    foreach (ar_cyc[i]) if (ar_cyc[i] < first_last) nb++;
    n_checks++; if (nb !== 4) $display("FAIL outst_before_rlast: got %0d ARs want 4", nb); else n_pass++;
    fifth = (ar_cyc.size() > 4) ? ar_cyc[4] : -1;
    n_checks++; if (fifth !== first_last + 1)
      $display("FAIL outst_fifth_ar: got cycle %0d want %0d", fifth, first_last + 1); else n_pass++;
    nb = count_bad(base, 128);
    n_checks++; if (t_log.size() !== 128 || nb !== 0)
      $display("FAIL outst_data: got %0d beats %0d bad want 128 beats 0 bad", t_log.size(), nb); else n_pass++;
    r_hold = 0;
    end_cmd();
  endtask

  task automatic test_zero_burst();
    clear_logs();
    start_cmd(32'h3000_0000, 0);
    n_checks++; if (done !== 1'b0) $display("FAIL zero_done_early: got %b want 0", done); else n_pass++;
    tick();
    tick();
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else n_pass++;
    n_checks++; if (ar_log.size() !== 0 || m_axi_arvalid !== 1'b0)
      $display("FAIL zero_no_ar: got ars=%0d arvalid=%b want 0 0", ar_log.size(), m_axi_arvalid); else n_pass++;
    start = 1'b0;
    tick();
    n_checks++; if (done !== 1'b0) $display("FAIL zero_done_fall: got %b want 0", done); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] base = 32'h4000_0000;
    bit ok;
    int bad;
    clear_logs();
    tready_rand = 1'b1;
    start_cmd(base, 2);
    wait_done(3000, ok);
    tready_rand = 1'b0;
    n_checks++; if (!ok) $display("FAIL bp_done: got %b want 1 within 3000 cycles", done); else n_pass++;
    n_checks++; if (t_log.size() !== 32) $display("FAIL bp_beats: got %0d want 32", t_log.size()); else n_pass++;
    bad = count_bad(base, 32);
    n_checks++; if (bad !== 0) $display("FAIL bp_data: got %0d bad beats want 0", bad); else n_pass++;
`ifndef AXI_BURST_RD_SKID_EN
    n_checks++; if (viol !== 0) $display("FAIL bp_rready_gate: got %0d cycles rready&!tready want 0", viol); else n_pass++;
`endif
    end_cmd();
  endtask

  task automatic test_error_reset();
    logic [AW-1:0] base = 32'h5000_0000;
    bit ok;
    int bad, k;
    clear_logs();
    err_beat = 5;
    start_cmd(base, 2);
    wait_done(500, ok);
    n_checks++; if (!ok) $display("FAIL err_done: got %b want 1 within 500 cycles", done); else n_pass++;
    n_checks++; if (rd_err !== 1'b1) $display("FAIL err_rd_err: got %b want 1", rd_err); else n_pass++;
    bad = count_bad(base, 32);
    n_checks++; if (t_log.size() !== 32 || bad !== 0)
      $display("FAIL err_data: got %0d beats %0d bad want 32 beats 0 bad", t_log.size(), bad); else n_pass++;
    end_cmd();
    clear_logs();
    err_beat = 2;
    start_cmd(32'h6000_0000, 4);
    k = 0;
    while (t_log.size() < 8 && k < 200) begin
      tick();
      k++;
    end
    n_checks++; if (t_log.size() < 8) $display("FAIL rst_mid_reach: got %0d beats want >=8", t_log.size()); else n_pass++;
    n_checks++; if (rd_err !== 1'b1) $display("FAIL rst_pre_rd_err: got %b want 1", rd_err); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_checks++; if ({done, rd_err, m_axi_arvalid, m_axi_rready, m_axis_tvalid} !== 5'b0)
      $display("FAIL rst_mid_ctrl: got done,err,arv,rrdy,tv=%b want 00000",
               {done, rd_err, m_axi_arvalid, m_axi_rready, m_axis_tvalid}); else n_pass++;
    n_checks++; if (m_axi_araddr !== '0) $display("FAIL rst_mid_araddr: got %h want 0", m_axi_araddr); else n_pass++;
    start = 1'b0;
    err_beat = -1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] base = 32'h7000_0000;
    bit ok;
    int bad, gaps, late;
    clear_logs();
    start_cmd(base, 4);
    wait_done(500, ok);
    n_checks++; if (!ok) $display("FAIL b2b_done: got %b want 1 within 500 cycles", done); else n_pass++;
    bad = count_bad(base, 64);
    n_checks++; if (t_log.size() !== 64 || bad !== 0)
      $display("FAIL b2b_data: got %0d beats %0d bad want 64 beats 0 bad", t_log.size(), bad); else n_pass++;
    gaps = 0;
    late = 0;
    foreach (t_cyc[i]) begin
      if (t_cyc[i] !== t_cyc[0] + i) gaps++;
      if (i >= r_cyc.size() || t_cyc[i] !== r_cyc[i] + LAT) late++;
    end
    n_checks++; if (gaps !== 0) $display("FAIL b2b_throughput: got %0d gapped beats want 0", gaps); else n_pass++;
    n_checks++; if (late !== 0) $display("FAIL b2b_latency: got %0d beats off by latency %0d want 0", late, LAT); else n_pass++;
    end_cmd();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_outstanding();
    test_zero_burst();
    test_backpressure();
    test_error_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
